// File: rtl/usadd16_seq_ctrl.sv
// rtl/usadd16_seq_ctrl.sv - run/count/handshake sequencer for a scaled 16-input unary adder
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request one stream run (accepted only in IDLE, abort low)
//   cfg_len    stream length minus one, captured on the accepted start
//   abort      synchronous cancel of any run or pending result
//   add_out    adder output bit, counted in every RUN cycle
//   in_en      gate for adder inputs and bitstream generators (high only in RUN)
//   busy       high whenever not IDLE
//   res_valid  result available (DONE)
//   res_ready  consumer accepts the result
//   result     number of 1s seen on add_out during the last run
module usadd16_seq_ctrl #(
    parameter int CWIDTH = 8,
    parameter int RWIDTH = CWIDTH + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CWIDTH-1:0] cfg_len,
    input  logic              abort,
    input  logic              add_out,
    output logic              in_en,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RWIDTH-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CWIDTH-1:0] len_q;
    logic [CWIDTH-1:0] cyc_q;
    logic [RWIDTH-1:0] ones_q;
    logic              accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_en     = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start && !abort) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                in_en = 1'b1;
                // cyc counts from 0, so matching len_q gives len_q+1 RUN cycles
                if (cyc_q == len_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // abort overrides every transition, including a start in IDLE
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // ones is RWIDTH >= CWIDTH+1 wide, so 2^CWIDTH ones cannot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= '0;
            cyc_q  <= '0;
            ones_q <= '0;
        end else if (abort) begin
            cyc_q  <= '0;
            ones_q <= '0;
        end else if (accept) begin
            len_q  <= cfg_len;
            cyc_q  <= '0;
            ones_q <= '0;
        end else if (state_q == ST_RUN) begin
            cyc_q  <= cyc_q + CWIDTH'(1);
            ones_q <= ones_q + RWIDTH'(add_out);
        end
    end

    // ones is frozen outside RUN, so it holds through DONE and after the handshake
    assign result = ones_q;

endmodule

// File: tb/tb_usadd16_seq_ctrl.sv
// tb/tb_usadd16_seq_ctrl.sv - directed self-checking bench for usadd16_seq_ctrl
module tb_usadd16_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] cfg_len;
    logic       abort;
    logic       add_out;
    logic       in_en;
    logic       busy;
    logic       res_valid;
    logic       res_ready;
    logic [8:0] result;

    int checks;
    int failures;
    int n;
    int seen_valid;

    usadd16_seq_ctrl #(
        .CWIDTH(8),
        .RWIDTH(9)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_len  (cfg_len),
        .abort    (abort),
        .add_out  (add_out),
        .in_en    (in_en),
        .busy     (busy),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .result   (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // counts RUN cycles (in_en high) until the run ends, bounded
    task automatic count_run(output int cnt);
        cnt = 0;
        while (in_en === 1'b1 && cnt < 300) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b1;
        start      = 1'b0;
        cfg_len    = 8'd0;
        abort      = 1'b0;
        add_out    = 1'b0;
        res_ready  = 1'b0;
        #1 rst_n   = 1'b0;
        repeat (3) tick();
        chk("rst_in_en", in_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_result", result, 0);

        // cfg_len=7, ones on RUN cycles 0,2,5; start offered on first edge after release
        rst_n   = 1'b1;
        start   = 1'b1;
        cfg_len = 8'd7;
        tick();
        start = 1'b0;
        chk("s1_accept_first_edge", busy, 1);
        for (int i = 0; i < 8; i++) begin
            add_out = (i == 0 || i == 2 || i == 5) ? 1'b1 : 1'b0;
            if (i == 1) cfg_len = 8'd2;
            chk("s1_in_en_run", in_en, 1);
            chk("s1_no_valid_yet", res_valid, 0);
            tick();
        end
        add_out = 1'b0;
        chk("s1_valid_edge9", res_valid, 1);
        chk("s1_result", result, 3);
        chk("s1_in_en_done", in_en, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("s1_idle_after_hs", busy, 0);
        chk("s1_valid_drop", res_valid, 0);
        chk("s1_result_kept", result, 3);

        // cfg_len=0: single RUN cycle
        cfg_len = 8'd0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        add_out = 1'b1;
        count_run(n);
        chk("s2_len0_cycles", n, 1);
        chk("s2_len0_valid", res_valid, 1);
        chk("s2_len0_result", result, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // cfg_len=255 with add_out tied high: 256 cycles, result 256, no wrap
        cfg_len = 8'd255;
        start   = 1'b1;
        tick();
        start = 1'b0;
        count_run(n);
        add_out = 1'b0;
        chk("s2_len255_cycles", n, 256);
        chk("s2_len255_valid", res_valid, 1);
        chk("s2_len255_result", result, 256);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // DONE held with res_ready low, start pulses ignored
        cfg_len = 8'd1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        add_out = 1'b1;
        tick();
        tick();
        add_out = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start   = i[0];
            cfg_len = 8'd9;
            chk("s3_hold_valid", res_valid, 1);
            chk("s3_hold_result", result, 2);
            chk("s3_hold_busy", busy, 1);
            chk("s3_hold_in_en", in_en, 0);
            tick();
        end
        start     = 1'b1;
        res_ready = 1'b1;
        tick();
        start     = 1'b0;
        res_ready = 1'b0;
        chk("s3_hs_to_idle", busy, 0);
        chk("s3_hs_start_ignored", in_en, 0);

        // abort on RUN cycle 3 of cfg_len=15
        cfg_len = 8'd15;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        add_out = 1'b1;
        repeat (3) tick();
        chk("s4_run_cycle3", in_en, 1);
        abort = 1'b1;
        tick();
        abort   = 1'b0;
        add_out = 1'b0;
        chk("s4_abort_busy", busy, 0);
        chk("s4_abort_in_en", in_en, 0);
        chk("s4_abort_ones_clr", result, 0);
        seen_valid = 0;
        repeat (20) begin
            if (res_valid !== 1'b0) seen_valid++;
            tick();
        end
        chk("s4_never_valid", seen_valid, 0);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("s4_abort_start_idle", busy, 0);
        chk("s4_abort_start_in_en", in_en, 0);

        // abort in DONE discards the pending result
        cfg_len = 8'd0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        add_out = 1'b1;
        tick();
        add_out = 1'b0;
        chk("s4_done_valid", res_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s4_done_abort_valid", res_valid, 0);
        chk("s4_done_abort_result", result, 0);

        // reset mid-RUN, then a fresh cfg_len=3 run
        cfg_len = 8'd9;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        add_out = 1'b1;
        repeat (2) tick();
        chk("s5_mid_run", in_en, 1);
        rst_n = 1'b0;
        #1;
        chk("s5_async_in_en", in_en, 0);
        chk("s5_async_busy", busy, 0);
        chk("s5_async_valid", res_valid, 0);
        chk("s5_async_result", result, 0);
        tick();
        rst_n   = 1'b1;
        cfg_len = 8'd3;
        start   = 1'b1;
        tick();
        start = 1'b0;
        count_run(n);
        add_out = 1'b0;
        chk("s5_len3_cycles", n, 4);
        chk("s5_len3_result", result, 4);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // back-to-back with start held: handshake edge ignores start,
        // so exactly one IDLE cycle separates the runs
        cfg_len   = 8'd1;
        start     = 1'b1;
        res_ready = 1'b1;
        tick();
        chk("s6_r1_c0", in_en, 1);
        tick();
        chk("s6_r1_c1", in_en, 1);
        tick();
        chk("s6_done_in_en", in_en, 0);
        chk("s6_done_valid", res_valid, 1);
        tick();
        chk("s6_gap_in_en", in_en, 0);
        chk("s6_gap_busy", busy, 0);
        tick();
        chk("s6_r2_start", in_en, 1);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        res_ready = 1'b0;
        chk("s6_cleanup", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usadd16_seq_ctrl.md
USADD16_SEQ_CTRL -- requirements
Module: usadd16_seq_ctrl

Interface
REQ-001 The block SHALL provide parameter CWIDTH, default 8, the width of the stream-length configuration; maximum stream length is 2^CWIDTH cycles.
REQ-002 The block SHALL provide parameter RWIDTH, default CWIDTH+1, the width of the result; it SHALL be at least CWIDTH+1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to run one stream; it is accepted only in IDLE.
REQ-006 The block SHALL have port cfg_len, input, CWIDTH bits: stream length minus one; it is sampled on the accepted start.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous cancel of any run or pending result.
REQ-008 The block SHALL have port add_out, input, 1 bit: the output bit of the scaled 16-input unary adder; it is combinational from that adder's inputs in the same cycle.
REQ-009 The block SHALL have port in_en, output, 1 bit: gate applied to the 16 adder input streams and to the bitstream generators; low forces the adder inputs to 0.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 The block SHALL have port res_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-013 The block SHALL have port result, output, RWIDTH bits: count of 1s on add_out during the run.

Function
REQ-014 The block SHALL implement the FSM states IDLE, RUN and DONE, encoded with a single state register.
REQ-015 IDLE SHALL go to RUN when start=1 and abort=0; on that edge, len_q := cfg_len, cyc := 0 and ones := 0.
REQ-016 In RUN, in_en SHALL be 1 combinationally (state-decoded, not registered); in IDLE and DONE, in_en SHALL be 0.
REQ-017 In every RUN cycle, ones SHALL increment by 1 iff add_out=1, and cyc SHALL increment by 1.
REQ-018 RUN SHALL go to DONE on the edge where cyc==len_q, which gives exactly len_q+1 RUN cycles; that last cycle's add_out SHALL be included in ones.
REQ-019 In DONE, res_valid=1 and result=ones, and both SHALL be held stable until the handshake completes.
REQ-020 DONE SHALL go to IDLE on the edge where res_valid=1 and res_ready=1; result SHALL keep its last value after the handshake.
REQ-021 The latency from the accepted start to res_valid SHALL be exactly len_q+2 edges (len_q+1 RUN cycles plus the DONE entry).
REQ-022 start SHALL be ignored while busy=1, including in the handshake cycle; a new run can be accepted only on the first IDLE cycle.
REQ-023 cfg_len changes after acceptance SHALL have no effect on the current run.
REQ-024 abort=1 in any state SHALL force IDLE on the next edge with ones cleared; any pending result SHALL be discarded and res_valid SHALL drop on that edge.
REQ-025 If abort and start are both high in IDLE, abort SHALL win and no run SHALL start.
REQ-026 The ones counter SHALL never wrap: its maximum is 2^CWIDTH, which is less than 2^RWIDTH.
REQ-027 cfg_len=0 SHALL produce a one-cycle run; cfg_len=all-ones SHALL produce a 2^CWIDTH-cycle run.
REQ-028 The block SHALL not reset or flush the adder; a residual adder accumulation (<16) is carried into the next run by design.

Reset
REQ-029 While rst_n=0, the block SHALL hold state=IDLE, in_en=0, busy=0, res_valid=0, result=0, cyc=0, ones=0 and len_q=0, asynchronously.
REQ-030 rst_n asserted mid-RUN or in DONE SHALL abandon the run with no result; after release, the block SHALL wait for a new start.
REQ-031 The first edge after rst_n deasserts SHALL be able to accept start.

Verification
REQ-032 The bench SHALL cover this scenario: cfg_len=7, start pulse, add_out=1 on RUN cycles 0,2,5 -> in_en high 8 cycles, res_valid on edge 9, result=3.
REQ-033 The bench SHALL cover this scenario: cfg_len=0, add_out=1 -> one RUN cycle, result=1; cfg_len=255, add_out tied 1 -> 256 RUN cycles, result=256, no wrap.
REQ-034 The bench SHALL cover this scenario: res_ready=0 for 5 cycles in DONE -> res_valid and result stable, busy=1, start pulses ignored; res_ready=1 -> IDLE next edge.
REQ-035 The bench SHALL cover this scenario: abort on RUN cycle 3 of cfg_len=15 -> IDLE next edge, in_en=0, res_valid never asserted; abort+start together in IDLE -> stays IDLE.
REQ-036 The bench SHALL cover this scenario: rst_n pulsed low mid-RUN -> all outputs 0 immediately; a subsequent start with cfg_len=3 runs exactly 4 cycles.
REQ-037 The bench SHALL cover this scenario: back-to-back runs with start held high -> the second run starts on the first IDLE cycle after the handshake, with a one-cycle gap of in_en=0.
